// File: rtl/garage_door_ctrl_param.sv
// Parametrised garage door motor controller.
// Moore FSM (IDLE / MV_UP / MV_DN / STOPPED / FAULT) with a rising-edge
// Activate, pause/resume, obstruction reversal while closing, a travel
// watchdog and a sticky fault that only RST clears.
// Optional feature: define AUTO_CLOSE_EN to close a fully open door after
// AUTO_CLOSE_CYCLES idle cycles.
module garage_door_ctrl_param #(
  parameter int unsigned TIMEOUT_CYCLES    = 20000,
  parameter int unsigned AUTO_CLOSE_CYCLES = 50000,
  parameter int unsigned CNT_W             = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Obstruct,
  output logic       UP_M,
  output logic       DN_M,
  output logic       Fault,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MV_UP   = 3'd1,
    MV_DN   = 3'd2,
    STOPPED = 3'd3,
    FAULT   = 3'd4
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

`ifdef AUTO_CLOSE_EN
  localparam bit AC_EN = 1'b1;
`else
  localparam bit AC_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] AC_LAST = CNT_W'(AUTO_CLOSE_CYCLES - 1);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             act_pulse;

  assign act_d     = Activate;
  assign act_pulse = Activate & ~act_q;

  // State, direction, counter and Activate history registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
    end
  end

  // Next-state, counter and direction logic; cnt defaults to clear so any
  // state change (or any cycle that does not explicitly count) zeroes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dir_d   = dir_q;
    if (state_q != FAULT && UP_Max && DN_Max) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_pulse) begin
            state_d = UP_Max ? MV_DN : MV_UP;
          end else if (AC_EN && UP_Max && !DN_Max && !Obstruct) begin
            if (cnt_q == AC_LAST) state_d = MV_DN;
            else                  cnt_d   = cnt_q + 1'b1;
          end
        end
        MV_UP: begin
          if (UP_Max)                 state_d = IDLE;
          else if (act_pulse)         state_d = STOPPED;
          else if (cnt_q == TO_LAST)  state_d = FAULT;
          else                        cnt_d   = cnt_q + 1'b1;
        end
        MV_DN: begin
          if (DN_Max)                 state_d = IDLE;
          else if (Obstruct)          state_d = MV_UP;
          else if (act_pulse)         state_d = STOPPED;
          else if (cnt_q == TO_LAST)  state_d = FAULT;
          else                        cnt_d   = cnt_q + 1'b1;
        end
        STOPPED: begin
          if (act_pulse) state_d = (dir_q == DIR_UP) ? MV_DN : MV_UP;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    if (state_d == MV_UP && state_q != MV_UP) dir_d = DIR_UP;
    if (state_d == MV_DN && state_q != MV_DN) dir_d = DIR_DN;
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    UP_M  = (state_q == MV_UP);
    DN_M  = (state_q == MV_DN);
    Fault = (state_q == FAULT);
    State = state_q;
  end

endmodule

// File: tb/tb_garage_door_ctrl_param.sv
// Self-checking bench for garage_door_ctrl_param (TIMEOUT=20, AUTO_CLOSE=10).
// Directed vector table, hand sequences for multi-cycle corners, then
// randomized stimulus against a behavioural door model.
module tb_garage_door_ctrl_param;

  localparam int TO = 20;
  localparam int AC = 10;
`ifdef AUTO_CLOSE_EN
  localparam bit AC_ON = 1'b1;
`else
  localparam bit AC_ON = 1'b0;
`endif

  // {UP_M, DN_M, Fault, State}
  localparam logic [5:0] O_IDLE = 6'b000_000;
  localparam logic [5:0] O_UP   = 6'b100_001;
  localparam logic [5:0] O_DN   = 6'b010_010;
  localparam logic [5:0] O_STOP = 6'b000_011;
  localparam logic [5:0] O_FLT  = 6'b001_100;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Activate = 1'b0, UP_Max = 1'b0, DN_Max = 1'b0, Obstruct = 1'b0;
  logic       UP_M, DN_M, Fault;
  logic [2:0] State;

  int total = 0;
  int bad   = 0;

  garage_door_ctrl_param #(
    .TIMEOUT_CYCLES(TO),
    .AUTO_CLOSE_CYCLES(AC),
    .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .Activate(Activate), .UP_Max(UP_Max),
    .DN_Max(DN_Max), .Obstruct(Obstruct), .UP_M(UP_M), .DN_M(DN_M),
    .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  // Behavioural door model: motion sign, pause flag, fault flag, timers.
  int m_move;      // +1 opening, -1 closing, 0 not moving
  bit m_paused;
  bit m_fault;
  bit m_prev_act;
  int m_last;      // last motion sign
  int m_elapsed;   // cycles spent in current motion
  int m_open_idle; // cycles parked fully open

  task automatic model_reset();
    m_move = 0; m_paused = 0; m_fault = 0; m_prev_act = 0;
    m_last = 1; m_elapsed = 0; m_open_idle = 0;
  endtask

  task automatic model_start(input int d);
    m_move = d; m_last = d; m_elapsed = 0; m_open_idle = 0; m_paused = 0;
  endtask

  task automatic model_step(input bit act, input bit up, input bit dn, input bit obs);
    bit pulse;
    pulse = act && !m_prev_act;
    m_prev_act = act;
    if (m_fault) return;
    if (up && dn) begin
      m_fault = 1; m_move = 0; m_paused = 0;
      return;
    end
    if (m_move != 0) begin
      if ((m_move > 0) ? up : dn)        m_move = 0;
      else if (m_move < 0 && obs)        model_start(1);
      else if (pulse) begin              m_paused = 1; m_move = 0; end
      else if (m_elapsed == TO - 1) begin m_fault = 1; m_move = 0; end
      else                               m_elapsed++;
    end else if (m_paused) begin
      if (pulse) model_start(-m_last);
    end else begin
      if (pulse) model_start(up ? -1 : 1);
      else if (AC_ON && up && !dn && !obs) begin
        if (m_open_idle == AC - 1) model_start(-1);
        else                       m_open_idle++;
      end else m_open_idle = 0;
    end
  endtask

  function automatic logic [5:0] model_outs();
    logic [2:0] st;
    if (m_fault)         st = 3'd4;
    else if (m_paused)   st = 3'd3;
    else if (m_move > 0) st = 3'd1;
    else if (m_move < 0) st = 3'd2;
    else                 st = 3'd0;
    return {m_move > 0 && !m_fault, m_move < 0 && !m_fault, m_fault, st};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {UP_M, DN_M, Fault, State};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {UP_M,DN_M,Fault,State}=%b required %b at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, take one edge, advance the model.
  task automatic step(input bit act, input bit up, input bit dn, input bit obs);
    @(negedge CLK);
    Activate = act; UP_Max = up; DN_Max = dn; Obstruct = obs;
    @(posedge CLK);
    model_step(act, up, dn, obs);
    #1;
  endtask

  // Asynchronous reset pulse, asserted mid-cycle; outputs must drop at once.
  task automatic do_reset(input string name);
    @(negedge CLK);
    Activate = 0; UP_Max = 0; DN_Max = 0; Obstruct = 0;
    #2 RST = 1'b0;
    #1 check(name, O_IDLE);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         act, up, dn, obs;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[25];

  initial begin
    vecs[0]  = '{0, 0, 1, 0, O_IDLE, "idle_closed"};
    vecs[1]  = '{1, 0, 1, 0, O_UP,   "open_start"};
    vecs[2]  = '{1, 0, 0, 0, O_UP,   "open_hold1"};
    vecs[3]  = '{1, 0, 0, 0, O_UP,   "open_hold2"};
    vecs[4]  = '{0, 0, 0, 0, O_UP,   "open_run3"};
    vecs[5]  = '{0, 0, 0, 0, O_UP,   "open_run4"};
    vecs[6]  = '{0, 1, 0, 0, O_IDLE, "open_limit"};
    vecs[7]  = '{0, 1, 0, 0, O_IDLE, "idle_open"};
    vecs[8]  = '{1, 1, 0, 0, O_DN,   "close_start"};
    vecs[9]  = '{0, 0, 0, 0, O_DN,   "close_run"};
    vecs[10] = '{0, 0, 0, 1, O_UP,   "obstruct_rev"};
    vecs[11] = '{1, 0, 0, 0, O_STOP, "pause_up"};
    vecs[12] = '{1, 0, 0, 1, O_STOP, "stop_ign_obs"};
    vecs[13] = '{0, 1, 0, 0, O_STOP, "stop_ign_lim"};
    vecs[14] = '{1, 0, 0, 0, O_DN,   "resume_dn"};
    vecs[15] = '{0, 0, 0, 0, O_DN,   "resume_dn_run"};
    vecs[16] = '{1, 0, 0, 0, O_STOP, "pause_dn"};
    vecs[17] = '{0, 0, 0, 0, O_STOP, "stop_wait"};
    vecs[18] = '{1, 0, 0, 0, O_UP,   "resume_up"};
    vecs[19] = '{0, 0, 1, 0, O_UP,   "up_ign_dnmax"};
    vecs[20] = '{0, 1, 1, 0, O_FLT,  "conflict_up"};
    vecs[21] = '{1, 0, 0, 0, O_FLT,  "fault_sticky1"};
    vecs[22] = '{0, 1, 0, 0, O_FLT,  "fault_sticky2"};
    vecs[23] = '{1, 0, 1, 0, O_FLT,  "fault_sticky3"};
    vecs[24] = '{0, 0, 0, 0, O_FLT,  "fault_sticky4"};

    model_reset();
    #2 check("reset_state", O_IDLE);
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].act, vecs[i].up, vecs[i].dn, vecs[i].obs);
      check(vecs[i].name, vecs[i].exp);
    end
    do_reset("rst_clears_fault");

    // Watchdog: motion lasts exactly TO cycles with no limit reached.
    step(1, 0, 0, 0);
    check("wd_start", O_UP);
    for (int i = 1; i < TO; i++) step(0, 0, 0, 0);
    check("wd_last_motion", O_UP);
    step(0, 0, 0, 0);
    check("wd_fault", O_FLT);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("wd_fault_sticky", O_FLT);
    do_reset("wd_async_rst");

    // Reset mid-motion drops the motor asynchronously.
    step(1, 1, 0, 0);
    check("mid_close", O_DN);
    do_reset("mid_motion_rst");
    step(1, 1, 0, 0);
    check("first_after_rst", O_DN);
    do_reset("rst2");

    // Activate held high: one transition only.
    step(1, 0, 1, 0);
    check("held_start", O_UP);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    check("held_no_retrig", O_UP);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("held_then_pulse", O_STOP);
    do_reset("rst3");

    // Same-edge priorities.
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    check("obs_beats_pulse", O_UP);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check("uplim_beats_pulse", O_IDLE);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("close_again", O_DN);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    check("dnlim_beats_pulse", O_IDLE);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 1, 0);
    check("conflict_dn", O_FLT);
    do_reset("rst4");

    // Door parked fully open.
`ifdef AUTO_CLOSE_EN
    for (int i = 1; i < AC; i++) step(0, 1, 0, 0);
    check("ac_wait", O_IDLE);
    step(0, 1, 0, 0);
    check("ac_close", O_DN);
    do_reset("rst5");
    for (int i = 1; i <= 15; i++) begin
      step(0, 1, 0, i == 5);
      if (i == 14) check("ac_obs_wait", O_IDLE);
    end
    check("ac_obs_close", O_DN);
    do_reset("rst5b");
`else
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0);
    check("no_autoclose", O_IDLE);
    do_reset("rst5");
`endif

    // Randomized stimulus against the model.
    for (int r = 0; r < 4; r++) begin
      bit a, u, d, o;
      a = 0;
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 3) == 0) a = ~a;
        u = ($urandom_range(0, 11) == 0);
        d = ($urandom_range(0, 11) == 0);
        o = ($urandom_range(0, 5) == 0);
        step(a, u, d, o);
        check("random", model_outs());
      end
      do_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
